// File: rtl/xosera_bus_sequencer_if.sv
// Request/response port and Xosera byte-bus signals of the bus sequencer.
// The master side is the CPU decode plus the Xosera read-data return.
// The slave side is the sequencer itself.
interface xosera_bus_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rd;
  logic [3:0]  req_reg;
  logic [15:0] req_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        busy;
  logic        bus_cs_n;
  logic        bus_rd_nwr;
  logic [3:0]  bus_reg_num;
  logic        bus_bytesel;
  logic [7:0]  bus_data_o;
  logic [7:0]  bus_data_i;

  modport master (
    output req_valid, req_rd, req_reg, req_data, bus_data_i,
    input  req_ready, rsp_valid, rsp_data, busy,
           bus_cs_n, bus_rd_nwr, bus_reg_num, bus_bytesel, bus_data_o
  );

  modport slave (
    input  req_valid, req_rd, req_reg, req_data, bus_data_i,
    output req_ready, rsp_valid, rsp_data, busy,
           bus_cs_n, bus_rd_nwr, bus_reg_num, bus_bytesel, bus_data_o
  );
endinterface

// File: rtl/xosera_bus_sequencer.sv
// Xosera bus sequencer: queues 16-bit register requests and plays each one
// out as two byte phases (high, then low) on the 8-bit strobed Xosera bus.
// Each phase is one setup cycle, CS_CYCLES of chip select, and GAP_CYCLES of
// recovery. Reads return {high byte, low byte} as a one-cycle rsp_valid pulse.
module xosera_bus_sequencer #(
  parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
  parameter int CS_CYCLES  = 2,   // >= 1
  parameter int GAP_CYCLES = 1    // >= 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  xosera_bus_sequencer_if.slave io
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int TMR_MAX = (CS_CYCLES > GAP_CYCLES) ? CS_CYCLES : GAP_CYCLES;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  localparam logic [TMR_W-1:0] CS_RELOAD  = TMR_W'(CS_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_RELOAD = TMR_W'(GAP_CYCLES - 1);

  typedef struct packed {
    logic        rd;
    logic [3:0]  regn;
    logic [15:0] data;
  } req_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP_HI,
    STROBE_HI,
    GAP_HI,
    SETUP_LO,
    STROBE_LO,
    GAP_LO
  } state_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  req_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             req_ready;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  req_t             head;
  req_t             push_entry;

  // FSM state and registered bus/response outputs
  state_t           state_q;
  logic [TMR_W-1:0] tmr_q;
  logic             wrk_rd_q;
  logic [7:0]       wrk_lo_q;
  logic [7:0]       hi_q;
  logic [7:0]       lo_q;
  logic             cs_n_q;
  logic             rd_nwr_q;
  logic [3:0]       reg_num_q;
  logic             bytesel_q;
  logic [7:0]       data_o_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_data_q;

  // Ready depends only on occupancy, so a full FIFO refuses a push even in a
  // cycle where the FSM pops.
  assign req_ready  = (count_q != CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = io.req_valid && req_ready;
  assign push_entry = '{rd: io.req_rd, regn: io.req_reg, data: io.req_data};
  assign head       = fifo_mem[rd_ptr_q];

  // The FSM takes the head when idle, or at the end of the last low-byte gap
  // so consecutive transactions run with no idle cycle between them.
  assign pop = !fifo_empty &&
               ((state_q == IDLE) || ((state_q == GAP_LO) && (tmr_q == '0)));

  // Request storage write.
  // NOTE: the storage array has no reset; only pointers and count are reset,
  // and an entry is never read before it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_entry;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // ---------------------------------------------------------------------------
  // Byte-phase sequencer with registered bus outputs
  // ---------------------------------------------------------------------------
  // Phase sequencing, strobe timing, read capture and response pulse.
  // NOTE: all state here uses non-blocking assignments, so the launch block at
  // the bottom can override the GAP_LO -> IDLE transition: the last
  // non-blocking write to a register in a cycle wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      tmr_q       <= '0;
      wrk_rd_q    <= 1'b0;
      wrk_lo_q    <= 8'h00;
      hi_q        <= 8'h00;
      lo_q        <= 8'h00;
      cs_n_q      <= 1'b1;
      rd_nwr_q    <= 1'b1;
      reg_num_q   <= 4'h0;
      bytesel_q   <= 1'b0;
      data_o_q    <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
    end else begin
      rsp_valid_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // waiting for work; launch handled below
        end

        SETUP_HI: begin
          cs_n_q  <= 1'b0;
          tmr_q   <= CS_RELOAD;
          state_q <= STROBE_HI;
        end

        STROBE_HI: begin
          if (tmr_q == '0) begin
            if (wrk_rd_q) hi_q <= io.bus_data_i;
            cs_n_q  <= 1'b1;
            tmr_q   <= GAP_RELOAD;
            state_q <= GAP_HI;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        GAP_HI: begin
          if (tmr_q == '0) begin
            bytesel_q <= 1'b1;
            data_o_q  <= wrk_rd_q ? 8'h00 : wrk_lo_q;
            state_q   <= SETUP_LO;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        SETUP_LO: begin
          cs_n_q  <= 1'b0;
          tmr_q   <= CS_RELOAD;
          state_q <= STROBE_LO;
        end

        STROBE_LO: begin
          if (tmr_q == '0) begin
            if (wrk_rd_q) lo_q <= io.bus_data_i;
            cs_n_q  <= 1'b1;
            tmr_q   <= GAP_RELOAD;
            state_q <= GAP_LO;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        GAP_LO: begin
          if (tmr_q == '0) begin
            if (wrk_rd_q) begin
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= {hi_q, lo_q};
            end
            state_q <= IDLE;
          end else begin
            tmr_q <= tmr_q - TMR_W'(1);
          end
        end

        default: begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
        end
      endcase

      // Launch the next request: latch it and present the high-byte setup.
      if (pop) begin
        state_q   <= SETUP_HI;
        wrk_rd_q  <= head.rd;
        wrk_lo_q  <= head.data[7:0];
        reg_num_q <= head.regn;
        rd_nwr_q  <= head.rd;
        bytesel_q <= 1'b0;
        data_o_q  <= head.rd ? 8'h00 : head.data[15:8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign io.req_ready   = req_ready;
  assign io.busy        = !fifo_empty || (state_q != IDLE);
  assign io.rsp_valid   = rsp_valid_q;
  assign io.rsp_data    = rsp_data_q;
  assign io.bus_cs_n    = cs_n_q;
  assign io.bus_rd_nwr  = rd_nwr_q;
  assign io.bus_reg_num = reg_num_q;
  assign io.bus_bytesel = bytesel_q;
  assign io.bus_data_o  = data_o_q;

endmodule
